// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU front-end types and defaults. These are used by the
//               fetch stage, the PC datapath and the instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          CPU_ADDR_W   = 32;
    localparam int          CPU_DATA_W   = 32;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;
    localparam int          INSTR_BYTES  = 4;

    // Fetch sequencer states: waiting on memory, or presenting to decode
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        OUT   = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// ============================================================================
// Module      : fetch_out_buf
// Description : Holding register for the fetched {instr, pc, pc+4} bundle.
//               It presents the bundle to decode with a valid/ready handshake.
//               A flush drops any held entry.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_out_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [ADDR_W-1:0] load_pc4,
    input  logic              flush,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4
);

    // Flush beats load so a redirected fetch never surfaces; data holds under backpressure
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
            pc4   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
            pc4   <= load_pc4;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. It issues one imem request at a time,
//               sequences the PC by 4, and accepts branch/jump redirects.
//               If a redirect arrives while a request is in flight, that
//               request is completed and its data is dropped. Each fetched
//               instruction goes to decode via valid/ready. All outputs
//               are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = CPU_ADDR_W,
    parameter int                DATA_W   = CPU_DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(CPU_RESET_PC)
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [DATA_W-1:0] id_instr,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc4
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_addr;
    logic              drop;

    logic [ADDR_W-1:0] req_addr_plus4;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              ack_accept;
    logic              buf_load;

    // Wrap-around is natural: the sum is truncated to ADDR_W bits
    assign req_addr_plus4   = req_addr + ADDR_W'(INSTR_BYTES);
    assign redirect_aligned = redirect_pc & ~ADDR_W'(3);
    // An ack without an outstanding request is meaningless and ignored
    assign ack_accept       = imem_req && imem_ack;
    assign buf_load         = !reset && !redirect_valid && (state == FETCH)
                              && ack_accept && !drop;
    assign imem_addr        = req_addr;

    // Fetch sequencer: reset > redirect > normal FETCH/OUT sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            imem_req <= 1'b0;
            drop     <= 1'b0;
        end else if (redirect_valid) begin
            state <= FETCH;
            pc    <= redirect_aligned;
            if (ack_accept) begin
                // The data arriving now is wrong-path; nothing is left to drop
                imem_req <= 1'b0;
                drop     <= 1'b0;
            end else if (imem_req) begin
                // Keep the bus transaction alive, and discard its data when it lands
                drop <= 1'b1;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                        req_addr <= pc;
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (drop) begin
                            drop <= 1'b0;
                        end else begin
                            pc    <= req_addr_plus4;
                            state <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (id_valid && id_ready) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    fetch_out_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk        (clk),
        .reset      (reset),
        .load       (buf_load),
        .load_instr (imem_rdata),
        .load_pc    (req_addr),
        .load_pc4   (req_addr_plus4),
        .flush      (redirect_valid),
        .ready      (id_ready),
        .valid      (id_valid),
        .instr      (id_instr),
        .pc         (id_pc),
        .pc4        (id_pc4)
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Randomised bench for if_fetch_unit. It contains a
//               variable-latency memory and a program-order reference model.
//               The model tracks the address of the next instruction that
//               decode should receive.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    if_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc4         (id_pc4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: the address decode must see next, in program order
    logic [31:0] model_pc     = 32'h0;
    bit          mem_busy     = 1'b0;
    int          mem_left     = 0;
    logic [31:0] mem_addr_exp = 32'h0;
    bit          prev_reset   = 1'b0;
    bit          prev2_reset  = 1'b0;
    bit          prev_redir   = 1'b0;
    bit          prev_ack     = 1'b0;
    int          idle         = 0;
    int          deliveries   = 0;

    // Stimulus knobs
    bit          k_reset      = 1'b0;
    int          k_ready_pct  = 100;
    int          k_lat_min    = 1;
    int          k_lat_max    = 1;
    int          k_redir_pct  = 0;
    int          k_redir_mode = 0;   // 0 random, 1 now, 2 on ack, 3 while waiting
    logic [31:0] k_target     = 32'h0;
    bit          k_stale_ack  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] rand_target();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            2:       return 32'($urandom_range(0, 63));
            default: return 32'h0000_0100;
        endcase
    endfunction

    // One clock: check outputs mid-cycle, choose inputs, then advance the model
    task automatic step();
        bit          rst_now;
        bit          rd_now;
        bit          rdy_now;
        bit          ack_now;
        logic [31:0] tgt;
        @(negedge clk);

        if (prev_reset) begin
            chk("rst_imem_req",  32'(imem_req), 32'h0);
            chk("rst_imem_addr", imem_addr,     32'h0);
            chk("rst_id_valid",  32'(id_valid), 32'h0);
            chk("rst_id_instr",  id_instr,      32'h0);
            chk("rst_id_pc",     id_pc,         32'h0);
            chk("rst_id_pc4",    id_pc4,        32'h0);
        end
        if (prev2_reset && !prev_reset && !prev_redir)
            chk("first_req", 32'(imem_req), 32'h1);
        if (id_valid) begin
            chk("id_pc",       id_pc,         model_pc);
            chk("id_pc4",      id_pc4,        model_pc + 32'd4);
            chk("id_instr",    id_instr,      mem_word(model_pc));
            chk("no_prefetch", 32'(imem_req), 32'h0);
        end
        if (prev_redir) chk("flush_valid", 32'(id_valid), 32'h0);
        if (prev_ack)   chk("req_after_ack", 32'(imem_req), 32'h0);
        if (imem_req && !mem_busy) begin
            chk("fetch_addr", imem_addr, model_pc);
            mem_busy     = 1'b1;
            mem_addr_exp = model_pc;
            mem_left     = $urandom_range(k_lat_min, k_lat_max);
        end else if (imem_req) begin
            chk("addr_hold", imem_addr, mem_addr_exp);
        end

        rst_now    = k_reset;
        ack_now    = 1'b0;
        imem_rdata = $urandom;
        if (imem_req && mem_busy) begin
            mem_left--;
            if (mem_left <= 0) begin
                ack_now    = 1'b1;
                imem_rdata = mem_word(imem_addr);
                mem_busy   = 1'b0;
            end
        end
        if (k_stale_ack && !imem_req) ack_now = 1'b1;

        case (k_redir_mode)
            1:       rd_now = 1'b1;
            2:       rd_now = ack_now && imem_req;
            3:       rd_now = imem_req && !ack_now;
            default: rd_now = (k_redir_pct > 0) && ($urandom_range(0, 99) < k_redir_pct);
        endcase
        tgt = (k_redir_mode != 0) ? k_target : rand_target();
        if (rd_now) k_redir_mode = 0;
        rdy_now = ($urandom_range(0, 99) < k_ready_pct);
        if (rst_now) mem_busy = 1'b0;

        reset          = rst_now;
        redirect_valid = rd_now;
        redirect_pc    = tgt;
        id_ready       = rdy_now;
        imem_ack       = ack_now;

        if (rst_now) begin
            model_pc = 32'h0;
        end else if (rd_now) begin
            model_pc = tgt & 32'hFFFF_FFFC;
        end else if (id_valid && rdy_now) begin
            model_pc   = model_pc + 32'd4;
            deliveries++;
        end

        if (rst_now || rd_now || (id_valid && rdy_now)) idle = 0;
        else idle++;
        if (idle == 40) chk("stall_cycles", 32'(idle), 32'h0);

        prev2_reset = prev_reset;
        prev_reset  = rst_now;
        prev_redir  = rd_now && !rst_now;
        prev_ack    = ack_now && imem_req && !rst_now;
    endtask

    initial begin
        reset          = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;

        // Reset, then sequential fetch with a 1-cycle memory: one instruction per 3 cycles
        k_reset = 1'b1;
        repeat (3) step();
        k_reset    = 1'b0;
        deliveries = 0;
        repeat (12) step();
        chk("thruput_12cyc", 32'(deliveries), 32'd4);

        // Backpressure: held entry must stay put and no fetch may start
        k_ready_pct = 0;
        repeat (6) step();
        k_ready_pct = 100;
        repeat (6) step();

        // Redirect while a slow request is outstanding
        k_lat_min    = 3;
        k_lat_max    = 3;
        k_target     = 32'h0000_0100;
        k_redir_mode = 3;
        repeat (20) step();
        chk("redir_wait_hit", 32'(k_redir_mode), 32'h0);

        // Redirect coincident with the ack, unaligned target
        k_lat_min    = 1;
        k_lat_max    = 2;
        k_target     = 32'h0000_0203;
        k_redir_mode = 2;
        repeat (20) step();
        chk("redir_ack_hit", 32'(k_redir_mode), 32'h0);

        // Address wrap at the top of the space
        k_lat_max    = 1;
        k_target     = 32'hFFFF_FFFC;
        k_redir_mode = 1;
        repeat (12) step();

        // Random traffic
        k_lat_max   = 4;
        k_ready_pct = 70;
        k_redir_pct = 8;
        repeat (3000) step();

        // Reset together with a redirect in mid-transaction, followed by a stale ack
        k_redir_pct = 0;
        k_ready_pct = 100;
        k_lat_min   = 4;
        k_lat_max   = 4;
        for (int i = 0; i < 20 && !mem_busy; i++) step();
        k_reset      = 1'b1;
        k_target     = 32'h0000_0400;
        k_redir_mode = 1;
        step();
        k_reset     = 1'b0;
        k_stale_ack = 1'b1;
        step();
        k_stale_ack = 1'b0;
        k_lat_min   = 1;
        k_lat_max   = 1;
        repeat (20) step();

        @(negedge clk);
        chk("deliveries_seen", 32'(deliveries > 100), 32'h1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
